// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle for the 4-way round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       tmo;

  modport master (output req, input gnt, gnt_idx, gnt_valid, tmo);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, tmo);
endinterface

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter; the owner keeps the resource until it drops its request.
// Optional hold-time limit with forced rotation is enabled by defining TIMEOUT_EN.
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_4_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CW) <= HOLD_MAX) begin : g_param_check
    $error("rr_arbiter_4: illegal HOLD_MAX/CW combination");
  end

  // Returns {found, index}; search begins at start and wraps 3 -> 0.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] i;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      i = start + 2'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [0:0] state, state_nx;
  logic [1:0] last, last_nx;
  logic [1:0] idx_nx;
  logic       vld_nx;
  logic       tmo_nx;
  logic [3:0] gnt_nx;
  logic [2:0] win;
`ifdef TIMEOUT_EN
  logic [CW-1:0] cnt, cnt_nx;
`endif

  always_comb begin
    state_nx = state;
    last_nx  = last;
    idx_nx   = bus.gnt_idx;
    vld_nx   = bus.gnt_valid;
    tmo_nx   = 1'b0;
    win      = 3'b000;
`ifdef TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    case (state)
      IDLE: begin
        win = pick(bus.req, last + 2'd1);
        if (win[2]) begin
          state_nx = GRANT;
          idx_nx   = win[1:0];
          vld_nx   = 1'b1;
`ifdef TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[bus.gnt_idx]) begin
          // Owner released: hand over on this same edge when anyone else waits.
          last_nx = bus.gnt_idx;
          win     = pick(bus.req, bus.gnt_idx + 2'd1);
          if (win[2]) begin
            idx_nx = win[1:0];
`ifdef TIMEOUT_EN
            cnt_nx = '0;
`endif
          end else begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            vld_nx   = 1'b0;
          end
        end
`ifdef TIMEOUT_EN
        else if (cnt == CW'(HOLD_MAX - 1)) begin
          // Hold limit reached: rotate only if a competitor is waiting.
          win    = pick(bus.req & ~decode(bus.gnt_idx), bus.gnt_idx + 2'd1);
          cnt_nx = '0;
          if (win[2]) begin
            last_nx = bus.gnt_idx;
            idx_nx  = win[1:0];
            tmo_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
    gnt_nx = vld_nx ? decode(idx_nx) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 2'd3;
      bus.gnt       <= 4'b0000;
      bus.gnt_idx   <= 2'd0;
      bus.gnt_valid <= 1'b0;
      bus.tmo       <= 1'b0;
    end else begin
      state         <= state_nx;
      last          <= last_nx;
      bus.gnt       <= gnt_nx;
      bus.gnt_idx   <= idx_nx;
      bus.gnt_valid <= vld_nx;
      bus.tmo       <= tmo_nx;
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nx;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: a behavioural model queues expected outputs per cycle.
// Timeout scenarios are exercised when TIMEOUT_EN is defined.
module tb_rr_arbiter_4;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_arbiter_4_if bus();

  rr_arbiter_4 #(.HOLD_MAX(HOLD), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit m_valid;
  int m_idx, m_last, m_cnt;
  bit m_tmo;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int find(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_last = 3; m_cnt = 0; m_tmo = 0;
  endtask

  task automatic model_grant(input int w);
    m_valid = 1; m_idx = w; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    m_tmo = 0;
    if (!m_valid) begin
      w = find(r, m_last + 1);
      if (w >= 0) model_grant(w);
    end else if (!r[m_idx]) begin
      m_last = m_idx;
      w = find(r, m_idx + 1);
      if (w >= 0) model_grant(w);
      else begin m_valid = 0; m_idx = 0; end
    end else begin
`ifdef TIMEOUT_EN
      if (m_cnt == HOLD - 1) begin
        logic [3:0] others;
        others = r;
        others[m_idx] = 1'b0;
        w = find(others, m_idx + 1);
        m_cnt = 0;
        if (w >= 0) begin m_last = m_idx; model_grant(w); m_tmo = 1; end
      end else m_cnt++;
`endif
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = m_valid ? (4'b0001 << m_idx) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.valid = m_valid;
    e.tmo   = m_tmo;
    return e;
  endfunction

  task automatic step(input logic [3:0] r);
    exp_t e;
    bus.req = r;
    model_step(r);
    sb.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("gnt", bus.gnt, e.gnt);
      chk("gnt_idx", bus.gnt_idx, e.idx);
      chk("gnt_valid", bus.gnt_valid, e.valid);
      chk("tmo", bus.tmo, e.tmo);
    end
    chk("onehot0", $onehot0(bus.gnt), 1);
    if (bus.gnt_valid) chk("decode", bus.gnt, 4'b0001 << bus.gnt_idx);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic v, input logic t);
    chk({tag, "_gnt"}, bus.gnt, g);
    chk({tag, "_idx"}, bus.gnt_idx, i);
    chk({tag, "_valid"}, bus.gnt_valid, v);
    chk({tag, "_tmo"}, bus.tmo, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    model_reset();
    sb.delete();
    #1;
    expect_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cur;
    bus.req = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single request, one-cycle latency
    step(4'b0001);
    expect_out("t1", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Back-to-back rotation 0,1,2,3,0
    do_reset();
    step(4'b1111); expect_out("t2_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1110); expect_out("t2_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1101); expect_out("t2_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b1011); expect_out("t2_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0111); expect_out("t2_4", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner 2 releases to idle, then search from 3 wraps to 1
    step(4'b0100); expect_out("t3_own", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0000); expect_out("t3_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0110); expect_out("t3_wrap", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a grant
    step(4'b0000);
    step(4'b0100); expect_out("t4_own", 4'b0100, 2'd2, 1'b1, 1'b0);
    do_reset();
    step(4'b1111); expect_out("t4_after", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef TIMEOUT_EN
    // Forced rotation after HOLD cycles with a competitor waiting
    do_reset();
    step(4'b0011); expect_out("t5_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(4'b0011); expect_out("t5_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0011); expect_out("t5_rot1", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(4'b0011); expect_out("t5_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step(4'b0011); expect_out("t5_rot0", 4'b0001, 2'd0, 1'b1, 1'b1);
`endif

    // Lone requester held for a long time keeps the grant, no timeout pulse
    do_reset();
    step(4'b0100);
    for (int i = 0; i < 20; i++) begin
      step(4'b0100); expect_out("t6_lone", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
`ifndef TIMEOUT_EN
    do_reset();
    step(4'b0011);
    for (int i = 0; i < 20; i++) begin
      step(4'b0011); expect_out("t6_nolimit", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    // Random traffic with sticky requests against the model
    do_reset();
    cur = 4'($urandom_range(0, 15));
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ 4'($urandom_range(1, 15));
      step(cur);
    end

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
